lat_tester_multi: RTL and testbench

LAT_TESTER_MULTI -- requirements
Module: lat_tester_multi

---
 rtl/lat_tester_pkg.sv | 20 ++
 rtl/lt_tick_div.sv | 38 +++
 rtl/lat_tester_multi.sv | 203 ++++++++++++++++++++
 tb/tb_lat_tester_multi.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lat_tester_pkg.sv
// Shared types and default constants for the latency tester.
package lat_tester_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLatMeas,
        StStbMeas,
        StRearm,
        StFinished
    } state_e;

    localparam int unsigned TICK_DIV_DEFAULT = 270;
    localparam int unsigned STB_MIN_DEFAULT  = 100;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lt_tick_div.sv
// Result-tick prescaler: one tick per TICK_DIV clk27 cycles, restartable via clr.
module lt_tick_div
    import lat_tester_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic clk27,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int unsigned    CntW   = cnt_width(TICK_DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    always_comb begin
        tick  = 1'b0;
        cnt_d = cnt_q + 1'b1;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            tick  = 1'b1;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk27) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lat_tester_multi.sv
// Multi-sample display latency tester: measures trigger->sensor latency and sensor settling.
// Optional LT_MINMAX_EN adds per-run latency minimum/maximum outputs.
module lat_tester_multi
    import lat_tester_pkg::*;
#(
    parameter int unsigned TICK_DIV   = TICK_DIV_DEFAULT,
    parameter int unsigned LAT_W      = 16,
    parameter int unsigned STB_W      = 12,
    parameter int unsigned STB_MIN    = STB_MIN_DEFAULT,
    parameter int unsigned NSAMP_LOG2 = 3
) (
    input  logic                  clk27,
    input  logic                  reset,
    input  logic                  active,
    input  logic                  armed,
    input  logic                  trigger,
    input  logic                  sensor,
    output logic [LAT_W-1:0]      lat_result,
    output logic [STB_W-1:0]      stb_result,
    output logic [LAT_W-1:0]      lat_avg,
    output logic [NSAMP_LOG2:0]   sample_cnt,
    output logic                  trig_waiting,
    output logic                  timeout,
`ifdef LT_MINMAX_EN
    output logic [LAT_W-1:0]      lat_min,
    output logic [LAT_W-1:0]      lat_max,
`endif
    output logic                  finished
);

    localparam int unsigned        AccW   = LAT_W + NSAMP_LOG2;
    localparam logic [NSAMP_LOG2:0] NSamp  = (NSAMP_LOG2 + 1)'(1 << NSAMP_LOG2);
    localparam logic [STB_W-1:0]   StbMin = STB_W'(STB_MIN);

    logic [1:0] trig_sync_q;
    logic [1:0] sens_sync_q;
    logic       trig_s;
    logic       sens_s;

    state_e                state_q, state_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic [STB_W-1:0]      stb_q, stb_d;
    logic [AccW-1:0]       acc_q, acc_d;
    logic [NSAMP_LOG2:0]   cnt_q, cnt_d;
    logic                  timeout_q, timeout_d;
    logic [LAT_W-1:0]      avg_q, avg_d;
    logic                  low_seen_q, low_seen_d;
`ifdef LT_MINMAX_EN
    logic [LAT_W-1:0]      min_q, min_d;
    logic [LAT_W-1:0]      max_q, max_d;
`endif

    logic presc_clr;
    logic tick;
    logic sample_done;

    assign trig_s = trig_sync_q[1];
    assign sens_s = sens_sync_q[1];

    lt_tick_div #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_div (
        .clk27 (clk27),
        .reset (reset),
        .clr   (presc_clr),
        .tick  (tick)
    );

    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        stb_d       = stb_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        timeout_d   = timeout_q;
        avg_d       = avg_q;
        low_seen_d  = low_seen_q;
`ifdef LT_MINMAX_EN
        min_d       = min_q;
        max_d       = max_q;
`endif
        presc_clr   = 1'b1;
        sample_done = 1'b0;

        unique case (state_q)
            StIdle: begin
                lat_d     = '0;
                stb_d     = '0;
                acc_d     = '0;
                cnt_d     = '0;
                timeout_d = 1'b0;
`ifdef LT_MINMAX_EN
                min_d     = '1;
                max_d     = '0;
`endif
                if (armed && trig_s) state_d = StLatMeas;
            end
            StLatMeas: begin
                presc_clr = 1'b0;
                // Sensor edge wins over a simultaneous saturation.
                if (!sens_s) begin
                    state_d   = StStbMeas;
                    presc_clr = 1'b1;
                end else if (&lat_q) begin
                    timeout_d   = 1'b1;
                    sample_done = 1'b1;
                end else if (tick) begin
                    lat_d = lat_q + 1'b1;
                end
            end
            StStbMeas: begin
                presc_clr = 1'b0;
                if (&stb_q) begin
                    timeout_d   = 1'b1;
                    sample_done = 1'b1;
                end else if (sens_s && (stb_q >= StbMin)) begin
                    sample_done = 1'b1;
                end else if (tick) begin
                    stb_d = stb_q + 1'b1;
                end
            end
            StRearm: begin
                if (!low_seen_q) begin
                    if (!trig_s) begin
                        low_seen_d = 1'b1;
                        if (cnt_q == NSamp) begin
                            state_d = StFinished;
                            avg_d   = LAT_W'(acc_q >> NSAMP_LOG2);
                        end
                    end
                end else if (trig_s && armed) begin
                    state_d = StLatMeas;
                    lat_d   = '0;
                    stb_d   = '0;
                end
            end
            StFinished: begin
                if (!armed) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (sample_done) begin
            state_d    = StRearm;
            acc_d      = acc_q + AccW'(lat_q);
            cnt_d      = cnt_q + 1'b1;
            low_seen_d = 1'b0;
`ifdef LT_MINMAX_EN
            if (lat_q < min_q) min_d = lat_q;
            if (lat_q > max_q) max_d = lat_q;
`endif
        end

        if (!active) state_d = StIdle;
    end

    always_ff @(posedge clk27) begin
        if (reset) begin
            trig_sync_q <= '0;
            sens_sync_q <= '0;
            state_q     <= StIdle;
            lat_q       <= '0;
            stb_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
            avg_q       <= '0;
            low_seen_q  <= 1'b0;
`ifdef LT_MINMAX_EN
            min_q       <= '1;
            max_q       <= '0;
`endif
        end else begin
            trig_sync_q <= {trig_sync_q[0], trigger};
            sens_sync_q <= {sens_sync_q[0], sensor};
            state_q     <= state_d;
            lat_q       <= lat_d;
            stb_q       <= stb_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
            avg_q       <= avg_d;
            low_seen_q  <= low_seen_d;
`ifdef LT_MINMAX_EN
            min_q       <= min_d;
            max_q       <= max_d;
`endif
        end
    end

    assign lat_result   = lat_q;
    assign stb_result   = stb_q;
    assign lat_avg      = avg_q;
    assign sample_cnt   = cnt_q;
    assign timeout      = timeout_q;
    assign trig_waiting = (state_q == StLatMeas);
    assign finished     = (state_q == StFinished);
`ifdef LT_MINMAX_EN
    assign lat_min      = min_q;
    assign lat_max      = max_q;
`endif

endmodule

// File: tb/tb_lat_tester_multi.sv
// Scoreboard bench for lat_tester_multi (TICK_DIV=4, LAT_W=6, STB_W=8, two samples per run).
module tb_lat_tester_multi;

    localparam int TD   = 4;
    localparam int LW   = 6;
    localparam int SW   = 8;
    localparam int SMIN = 100;
    localparam int NL   = 1;
    localparam int LMAX = (1 << LW) - 1;

    logic          clk27 = 1'b0;
    logic          reset;
    logic          active;
    logic          armed;
    logic          trigger;
    logic          sensor;
    logic [LW-1:0] lat_result;
    logic [SW-1:0] stb_result;
    logic [LW-1:0] lat_avg;
    logic [NL:0]   sample_cnt;
    logic          trig_waiting;
    logic          timeout;
    logic          finished;
`ifdef LT_MINMAX_EN
    logic [LW-1:0] lat_min;
    logic [LW-1:0] lat_max;
`endif

    always #5 clk27 = ~clk27;

    lat_tester_multi #(
        .TICK_DIV   (TD),
        .LAT_W      (LW),
        .STB_W      (SW),
        .STB_MIN    (SMIN),
        .NSAMP_LOG2 (NL)
    ) dut (
        .clk27        (clk27),
        .reset        (reset),
        .active       (active),
        .armed        (armed),
        .trigger      (trigger),
        .sensor       (sensor),
        .lat_result   (lat_result),
        .stb_result   (stb_result),
        .lat_avg      (lat_avg),
        .sample_cnt   (sample_cnt),
        .trig_waiting (trig_waiting),
        .timeout      (timeout),
`ifdef LT_MINMAX_EN
        .lat_min      (lat_min),
        .lat_max      (lat_max),
`endif
        .finished     (finished)
    );

    typedef struct { int lat; int stb; int to; } samp_t;
    typedef struct { int avg; int mn; int mx; } run_t;

    samp_t sq[$];
    run_t  rq[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    run_to;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Raw offsets n are measured from the input change; the FSM counts from the cycle after
    // it sees each synchronised edge, so n raw cycles span n-1 measured cycles.
    function automatic int exp_lat(input int d);
        return (d == 0) ? LMAX : (d - 1) / TD;
    endfunction

    function automatic int exp_stb(input int d, input int h);
        int t;
        if (d == 0) return 0;
        t = (h - 1) / TD;
        return (t > SMIN) ? t : SMIN;
    endfunction

    // d: trigger->sensor-low offset (0 = never), h: low->final-high offset.
    task automatic do_sample(input int d, input int h, input bit glitch, input bit hold,
                             input bit drop_armed, input bit push);
        logic [NL:0] start;
        bit          done;
        if (push) begin
            if (d == 0) run_to = 1;
            sq.push_back('{exp_lat(d), exp_stb(d, h), run_to});
        end
        start   = sample_cnt;
        done    = 1'b0;
        trigger = 1'b1;
        for (int i = 1; i <= 3000; i++) begin
            @(posedge clk27);
            #1;
            if (i == 4 && !hold) trigger = 1'b0;
            if (drop_armed && i == 8) armed = 1'b0;
            if (drop_armed && i == 12) armed = 1'b1;
            if (d != 0 && i == d) sensor = 1'b0;
            if (glitch && d != 0 && i == d + 201) sensor = 1'b1;
            if (glitch && d != 0 && i == d + 209) sensor = 1'b0;
            if (d != 0 && i == d + h) sensor = 1'b1;
            if (sample_cnt != start) begin
                done = 1'b1;
                break;
            end
        end
        sensor = 1'b1;
        check("sample_completed", done, 1);
    endtask

    task automatic finish_run();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk27);
            #1;
            if (finished) begin
                seen = 1'b1;
                break;
            end
        end
        check("finished_seen", seen, 1);
        armed = 1'b0;
        repeat (3) @(posedge clk27);
        #1;
        check("finished_cleared", finished, 0);
    endtask

    // Two samples per run (NSAMP_LOG2 = 1).
    task automatic do_run(input int d0, input int h0, input int d1, input int h1,
                          input bit g0, input bit drop);
        int l0, l1;
        l0     = exp_lat(d0);
        l1     = exp_lat(d1);
        run_to = 0;
        rq.push_back('{(l0 + l1) >> NL, (l0 < l1) ? l0 : l1, (l0 > l1) ? l0 : l1});
        armed = 1'b1;
        do_sample(d0, h0, g0, 1'b0, drop, 1'b1);
        do_sample(d1, h1, 1'b0, 1'b0, drop, 1'b1);
        finish_run();
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_lat_result"}, lat_result, 0);
        check({tag, "_stb_result"}, stb_result, 0);
        check({tag, "_sample_cnt"}, sample_cnt, 0);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_finished"}, finished, 0);
        check({tag, "_trig_waiting"}, trig_waiting, 0);
    endtask

    // Monitor: a sample result appears when sample_cnt steps up, a run result when finished rises.
    logic [NL:0] prev_cnt = '0;
    logic        prev_fin = 1'b0;
    always @(negedge clk27) begin
        samp_t es;
        run_t  er;
        if (reset) begin
            prev_cnt = '0;
            prev_fin = 1'b0;
        end else begin
            if (sample_cnt != prev_cnt && sample_cnt != 0) begin
                if (sq.size() == 0) begin
                    check("unexpected_sample", sample_cnt, 0);
                end else begin
                    es = sq.pop_front();
                    check("lat_result", lat_result, es.lat);
                    check("stb_result", stb_result, es.stb);
                    check("timeout", timeout, es.to);
                end
            end
            if (finished && !prev_fin) begin
                if (rq.size() == 0) begin
                    check("unexpected_finish", finished, 0);
                end else begin
                    er = rq.pop_front();
                    check("lat_avg", lat_avg, er.avg);
`ifdef LT_MINMAX_EN
                    check("lat_min", lat_min, er.mn);
                    check("lat_max", lat_max, er.mx);
`endif
                end
            end
            prev_cnt = sample_cnt;
            prev_fin = finished;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got time limit, expected bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        active  = 1'b1;
        armed   = 1'b0;
        trigger = 1'b0;
        sensor  = 1'b1;
        repeat (3) @(posedge clk27);
        #1;
        reset = 1'b0;
        check_cleared("reset");
        check("reset_lat_avg", lat_avg, 0);
`ifdef LT_MINMAX_EN
        check("reset_lat_min", lat_min, LMAX);
        check("reset_lat_max", lat_max, 0);
`endif
        repeat (2) @(posedge clk27);
        #1;

        // 40 measured cycles of latency twice -> 10 ticks each.
        do_run(41, 41, 41, 41, 1'b0, 1'b0);
        // Sensor bounces high at stb 50, final release at stb 100.
        do_run(30, 401, 61, 2, 1'b1, 1'b0);
        // Saturated sample still counts; timeout stays set for the run.
        do_run(0, 2, 41, 41, 1'b0, 1'b0);

        // Trigger held high after a sample must not start the next one.
        run_to = 0;
        rq.push_back('{(exp_lat(25) + exp_lat(45)) >> NL, exp_lat(25), exp_lat(45)});
        armed = 1'b1;
        do_sample(25, 10, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (50) @(posedge clk27);
        #1;
        check("hold_sample_cnt", sample_cnt, 1);
        check("hold_trig_waiting", trig_waiting, 0);
        trigger = 1'b0;
        repeat (5) @(posedge clk27);
        #1;
        check("hold_low_trig_waiting", trig_waiting, 0);
        do_sample(45, 10, 1'b0, 1'b0, 1'b0, 1'b1);
        finish_run();

        // active dropped during stabilisation.
        run_to = 0;
        armed  = 1'b1;
        do_sample(41, 20, 1'b0, 1'b0, 1'b0, 1'b1);
        trigger = 1'b1;
        repeat (4) @(posedge clk27);
        #1;
        trigger = 1'b0;
        repeat (20) @(posedge clk27);
        #1;
        sensor = 1'b0;
        repeat (40) @(posedge clk27);
        #1;
        active = 1'b0;
        repeat (2) @(posedge clk27);
        #1;
        check_cleared("active_drop");
        sensor = 1'b1;
        armed  = 1'b0;
        active = 1'b1;
        repeat (5) @(posedge clk27);
        #1;

        // Reset mid-run after one completed sample.
        run_to = 0;
        armed  = 1'b1;
        do_sample(61, 2, 1'b0, 1'b0, 1'b0, 1'b1);
        trigger = 1'b1;
        repeat (4) @(posedge clk27);
        #1;
        trigger = 1'b0;
        repeat (30) @(posedge clk27);
        #1;
        sensor = 1'b0;
        repeat (20) @(posedge clk27);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk27);
        #1;
        reset  = 1'b0;
        sensor = 1'b1;
        armed  = 1'b0;
        check_cleared("mid_reset");
        check("mid_reset_lat_avg", lat_avg, 0);
`ifdef LT_MINMAX_EN
        check("mid_reset_lat_min", lat_min, LMAX);
        check("mid_reset_lat_max", lat_max, 0);
`endif
        repeat (5) @(posedge clk27);
        #1;

        // Latencies 5 and 9 -> average 7; accumulator must start clean after the reset.
        do_run(21, 30, 37, 30, 1'b0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            int d0, d1, h0, h1;
            d0 = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(9, 200));
            d1 = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(9, 200));
            h0 = $urandom_range(2, 500);
            h1 = $urandom_range(2, 500);
            do_run(d0, h0, d1, h1, 1'b0, 1'($urandom_range(0, 1)));
        end

        repeat (5) @(posedge clk27);
        #1;
        check("pending_samples", sq.size(), 0);
        check("pending_runs", rq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
